// File: rtl/alu_dispatch_if.sv
// Request/response bundle between register read, alu_dispatch and writeback.
// With ILLEGAL_TRAP_EN defined the response carries an extra 'illegal' flag.
interface alu_dispatch_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
`ifdef ILLEGAL_TRAP_EN
  logic            illegal;

  modport master (output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
                  input  in_ready, out_valid, wb_en, wb_rd, wb_data, br_taken, br_target, illegal);
  modport slave  (input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
                  output in_ready, out_valid, wb_en, wb_rd, wb_data, br_taken, br_target, illegal);
`else
  modport master (output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
                  input  in_ready, out_valid, wb_en, wb_rd, wb_data, br_taken, br_target);
  modport slave  (input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
                  output in_ready, out_valid, wb_en, wb_rd, wb_data, br_taken, br_target);
`endif
endinterface

// File: rtl/alu_dispatch.sv
// ALU issue stage: decodes RV32 R/I/B ops onto an external combinational ALU, captures its result
// and returns a writeback/branch response. Optional macro ILLEGAL_TRAP_EN adds the 'illegal' flag.
module alu_dispatch #(
  parameter int XLEN     = 32,
  parameter bit RST_PC_Z = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_dispatch_if.slave    bus,
  output logic [XLEN-1:0]  alu_in1,
  output logic [XLEN-1:0]  alu_in2,
  output logic [2:0]       alu_control,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero
);
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b011,
                         ALU_LT  = 3'b100, ALU_GE = 3'b101, ALU_EQ  = 3'b110;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_B = 7'b1100011;
  localparam logic [XLEN-1:0] SIGN_MASK = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] BR_RST    = RST_PC_Z ? '0 : '0;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;

  logic            live;
  logic            accept;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_b;
  logic [2:0]      d_ctl;
  logic [XLEN-1:0] d_in1, d_in2;
  logic            d_wb, d_br, d_inv, d_ill;
  logic            wb_en_q, br_taken_q, is_br, br_inv;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q, br_target_q;
  logic            unused_bits;

  assign op    = bus.instr[6:0];
  assign f3    = bus.instr[14:12];
  assign f7    = bus.instr[31:25];
  assign rd    = bus.instr[11:7];
  assign imm_i = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
  assign imm_b = {{(XLEN-12){bus.instr[31]}}, bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign unused_bits = ^bus.instr[19:15];

  // live gates in_ready for one cycle after reset so nothing is accepted on the reset-release edge
  assign bus.in_ready = live & ((state == IDLE) | ((state == RESP) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    d_ctl = ALU_ADD;
    d_in1 = '0;
    d_in2 = '0;
    d_wb  = 1'b0;
    d_br  = 1'b0;
    d_inv = 1'b0;
    d_ill = 1'b0;
    case (op)
      OP_R: begin
        d_in1 = bus.rs1_data;
        d_in2 = bus.rs2_data;
        d_wb  = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: d_ctl = ALU_ADD;
          {7'h20, 3'b000}: d_ctl = ALU_SUB;
          {7'h00, 3'b111}: d_ctl = ALU_AND;
          {7'h00, 3'b110}: d_ctl = ALU_OR;
          default:         d_ill = 1'b1;
        endcase
      end
      OP_I: begin
        d_in1 = bus.rs1_data;
        d_in2 = imm_i;
        d_wb  = 1'b1;
        case (f3)
          3'b000:  d_ctl = ALU_ADD;
          3'b111:  d_ctl = ALU_AND;
          3'b110:  d_ctl = ALU_OR;
          default: d_ill = 1'b1;
        endcase
      end
      OP_B: begin
        d_in1 = bus.rs1_data;
        d_in2 = bus.rs2_data;
        d_br  = 1'b1;
        case (f3)
          3'b000:  d_ctl = ALU_EQ;
          3'b001:  begin d_ctl = ALU_EQ; d_inv = 1'b1; end
          // signed compares reuse the unsigned ALU by flipping both sign bits
          3'b100:  begin d_ctl = ALU_LT; d_in1 = bus.rs1_data ^ SIGN_MASK; d_in2 = bus.rs2_data ^ SIGN_MASK; end
          3'b101:  begin d_ctl = ALU_GE; d_in1 = bus.rs1_data ^ SIGN_MASK; d_in2 = bus.rs2_data ^ SIGN_MASK; end
          3'b110:  d_ctl = ALU_LT;
          3'b111:  d_ctl = ALU_GE;
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_ctl = ALU_ADD;
      d_in1 = '0;
      d_in2 = '0;
      d_wb  = 1'b0;
      d_br  = 1'b0;
      d_inv = 1'b0;
    end
    if (rd == 5'd0) d_wb = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.out_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live        <= 1'b0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_control <= ALU_ADD;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= BR_RST;
      is_br       <= 1'b0;
      br_inv      <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        alu_in1     <= d_in1;
        alu_in2     <= d_in2;
        alu_control <= d_ctl;
        wb_en_q     <= d_wb;
        wb_rd_q     <= rd;
        br_target_q <= bus.pc + imm_b;
        is_br       <= d_br;
        br_inv      <= d_inv;
      end
      if (state == EXEC) begin
        wb_data_q  <= alu_result;
        br_taken_q <= is_br & (alu_zero ^ br_inv);
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (!rst_n)      illegal_q <= 1'b0;
    else if (accept) illegal_q <= d_ill;
  end
  assign bus.illegal = illegal_q & (state == RESP);
`endif

  assign bus.out_valid = (state == RESP);
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.br_target = br_target_q;
endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: behavioural ALU, scoreboard of expected responses, assertion checks.
module tb_alu_dispatch;
  typedef struct {
    logic        wb_en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        br;
    logic [31:0] tgt;
    logic        is_br;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic [2:0]  alu_control;
  logic        alu_zero;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  longint      hs_t[$];

  always #5 clk = ~clk;

  alu_dispatch_if bus();

  alu_dispatch dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // compare ops return 0 when true so alu_zero doubles as the condition flag
  always_comb begin
    alu_result = '0;
    case (alu_control)
      3'b000:  alu_result = alu_in1 & alu_in2;
      3'b001:  alu_result = alu_in1 | alu_in2;
      3'b010:  alu_result = alu_in1 + alu_in2;
      3'b011:  alu_result = alu_in1 - alu_in2;
      3'b100:  alu_result = (alu_in1 <  alu_in2) ? 32'd0 : 32'd1;
      3'b101:  alu_result = (alu_in1 >= alu_in2) ? 32'd0 : 32'd1;
      3'b110:  alu_result = (alu_in1 == alu_in2) ? 32'd0 : 32'd1;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(logic wb, logic [4:0] rd, logic [31:0] d, logic br,
                              logic [31:0] tgt, logic is_br, logic ill);
    exp_t e;
    e.wb_en = wb; e.rd = rd; e.data = d; e.br = br; e.tgt = tgt; e.is_br = is_br; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      chk("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        hs_t.push_back($time);
        chk("wb_en", 32'(bus.wb_en), 32'(e.wb_en));
        chk("br_taken", 32'(bus.br_taken), 32'(e.br));
        if (e.wb_en) begin
          chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
          chk("wb_data", bus.wb_data, e.data);
        end
        if (e.is_br) chk("br_target", bus.br_target, e.tgt);
`ifdef ILLEGAL_TRAP_EN
        chk("illegal", 32'(bus.illegal), 32'(e.ill));
`endif
      end
    end
  end

  // drive one request and hold it until the accepting edge; caller is at posedge+1
  task automatic issue(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    bit ok = 1'b0;
    bus.in_valid = 1'b1; bus.instr = ins; bus.pc = p; bus.rs1_data = a; bus.rs2_data = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    n_cmp++;
    assert (ok) else begin n_bad++; $error("FAIL accept_timeout observed=%0d expected=1", ok); end
    if (ok) sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) begin ok = 1'b1; break; end
    end
    n_cmp++;
    assert (ok) else begin n_bad++; $error("FAIL drain_timeout observed=%0d expected=1", ok); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_wb_en", 32'(bus.wb_en), 0);
    chk("rst_br_taken", 32'(bus.br_taken), 0);
    chk("rst_alu_control", 32'(alu_control), 32'd2);
    chk("rst_alu_in1", alu_in1, 0);
    chk("rst_alu_in2", alu_in2, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_br_target", bus.br_target, 0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // ADD x3,x1,x2
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7, mk(1, 3, 32'd12, 0, 0, 0, 0));
    chk("add_ctl", 32'(alu_control), 32'b010);
    chk("add_in1", alu_in1, 32'd5);
    chk("add_in2", alu_in2, 32'd7);
    @(posedge clk); #1;
    chk("add_out_valid", 32'(bus.out_valid), 1);
    drain();

    issue(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 32'h0, 32'd5, 32'd7, mk(1, 4, 32'hFFFF_FFFE, 0, 0, 0, 0));
    chk("sub_ctl", 32'(alu_control), 32'b011);
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd5), 32'h0, 32'hF0F0, 32'hFF00, mk(1, 5, 32'hF000, 0, 0, 0, 0));
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd6), 32'h0, 32'hF0F0, 32'hFF00, mk(1, 6, 32'hFFF0, 0, 0, 0, 0));
    issue(enc_i(12'h00F, 5'd1, 3'b110, 5'd7), 32'h0, 32'h10, 32'h0, mk(1, 7, 32'h1F, 0, 0, 0, 0));
    issue(enc_i(12'hFFF, 5'd1, 3'b111, 5'd8), 32'h0, 32'h1234, 32'h0, mk(1, 8, 32'h1234, 0, 0, 0, 0));
    drain();

    // BLT -1 < 1, signed via sign-bit flip
    issue(enc_b(13'd8, 5'd2, 5'd1, 3'b100), 32'h100, 32'hFFFF_FFFF, 32'd1, mk(0, 0, 0, 1, 32'h108, 1, 0));
    chk("blt_ctl", 32'(alu_control), 32'b100);
    chk("blt_in1", alu_in1, 32'h7FFF_FFFF);
    chk("blt_in2", alu_in2, 32'h8000_0001);
    issue(enc_b(13'h1FFC, 5'd2, 5'd1, 3'b001), 32'h200, 32'd9, 32'd9, mk(0, 0, 0, 0, 32'h1FC, 1, 0));
    chk("bne_ctl", 32'(alu_control), 32'b110);
    issue(enc_b(13'd16, 5'd2, 5'd1, 3'b000), 32'h200, 32'd9, 32'd9, mk(0, 0, 0, 1, 32'h210, 1, 0));
    issue(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b111), 32'h0, 32'd1, 32'hFFFF_FFFF, mk(0, 0, 0, 0, 32'hFFFF_FFF8, 1, 0));
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 32'h0, 32'd5, 32'd7, mk(0, 0, 0, 0, 0, 0, 0));
    drain();

    // ADDI x1,x0,-1 with consumer stalled
    bus.out_ready = 1'b0;
    issue(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1), 32'h0, 32'h0, 32'h0, mk(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0));
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", 32'(bus.out_valid), 1);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      chk("hold_wb_data", bus.wb_data, 32'hFFFF_FFFF);
      chk("hold_wb_rd", 32'(bus.wb_rd), 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    drain();

    // back-to-back accept in RESP
    hs_t.delete();
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd8), 32'h0, 32'd1, 32'd2, mk(1, 8, 32'd3, 0, 0, 0, 0));
    issue(enc_i(12'd5, 5'd1, 3'b000, 5'd9), 32'h0, 32'd10, 32'h0, mk(1, 9, 32'd15, 0, 0, 0, 0));
    drain();
    chk("b2b_count", 32'(hs_t.size()), 32'd2);
    if (hs_t.size() == 2) chk("b2b_gap", 32'(hs_t[1] - hs_t[0]), 32'd20);

    // reset while the op is in EXEC discards it
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7, mk(1, 3, 32'd12, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if (sb.size() > 0) void'(sb.pop_back());
    chk("exec_rst_out_valid", 32'(bus.out_valid), 0);
    chk("exec_rst_in_ready", 32'(bus.in_ready), 0);
    chk("exec_rst_wb_en", 32'(bus.wb_en), 0);
    chk("exec_rst_ctl", 32'(alu_control), 32'b010);
    @(posedge clk); #1;
    chk("exec_rst_in_ready_after", 32'(bus.in_ready), 1);
    @(negedge clk);
    chk("exec_rst_no_resp", 32'(bus.out_valid), 0);
    @(posedge clk); #1;

    // opcode 0000000 is illegal: ADD 0,0 and no writeback
    issue(32'h0000_0180, 32'h0, 32'd5, 32'd7, mk(0, 0, 0, 0, 0, 0, 1));
    chk("ill_ctl", 32'(alu_control), 32'b010);
    chk("ill_in1", alu_in1, 0);
    chk("ill_in2", alu_in2, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
